keypad_scan_ctrl: RTL and testbench

KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

---
 rtl/keypad_pkg.sv | 41 ++++
 rtl/scan_tick_gen.sv | 27 ++
 rtl/keypad_scan_ctrl.sv | 133 +++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Column drive is one-hot with column 0 on the MSB.
package keypad_pkg;

    localparam int SCAN_TICKS_DEF = 27_000;
    localparam int DEB_TICKS_DEF  = 8;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } kp_state_t;

    localparam logic [3:0] COL_0 = 4'b1000;
    localparam logic [3:0] COL_1 = 4'b0100;
    localparam logic [3:0] COL_2 = 4'b0010;
    localparam logic [3:0] COL_3 = 4'b0001;

    function automatic logic [3:0] col_onehot(input logic [1:0] idx);
        logic [3:0] oh;
        case (idx)
            2'd0:    oh = COL_0;
            2'd1:    oh = COL_1;
            2'd2:    oh = COL_2;
            default: oh = COL_3;
        endcase
        return oh;
    endfunction

    // Lowest set row wins when several rows are active together.
    function automatic logic [1:0] low_row(input logic [3:0] rows);
        logic [1:0] idx;
        if (rows[0])      idx = 2'd0;
        else if (rows[1]) idx = 2'd1;
        else if (rows[2]) idx = 2'd2;
        else              idx = 2'd3;
        return idx;
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider: one-cycle tick every SCAN_TICKS clocks.
// Tick is asserted while the counter sits at its terminal value.
module scan_tick_gen #(
    parameter int SCAN_TICKS = keypad_pkg::SCAN_TICKS_DEF
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(SCAN_TICKS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad column scanner with tick-based press/release debounce.
// Rows are synchronized, decisions happen only on scan ticks.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_TICKS = SCAN_TICKS_DEF,
    parameter int DEB_TICKS  = DEB_TICKS_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] filas_raw,
    output logic [3:0] columnas,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW = $clog2(DEB_TICKS + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_TICKS - 1);

    logic            tick;
    logic [3:0]      sync1;
    logic [3:0]      rows_s;
    kp_state_t       state;
    kp_state_t       state_n;
    logic [1:0]      col_idx;
    logic [1:0]      col_idx_n;
    logic [3:0]      rows_lat;
    logic [3:0]      rows_lat_n;
    logic [DW-1:0]   deb_cnt;
    logic [DW-1:0]   deb_cnt_n;
    logic [3:0]      key_code_n;
    logic            key_valid_n;

    scan_tick_gen #(
        .SCAN_TICKS(SCAN_TICKS)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= '0;
            rows_s <= '0;
        end else begin
            sync1  <= filas_raw;
            rows_s <= sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SCAN;
            col_idx   <= '0;
            rows_lat  <= '0;
            deb_cnt   <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
        end else begin
            state     <= state_n;
            col_idx   <= col_idx_n;
            rows_lat  <= rows_lat_n;
            deb_cnt   <= deb_cnt_n;
            key_code  <= key_code_n;
            key_valid <= key_valid_n;
        end
    end

    always_comb begin
        state_n     = state;
        col_idx_n   = col_idx;
        rows_lat_n  = rows_lat;
        deb_cnt_n   = deb_cnt;
        key_code_n  = key_code;
        key_valid_n = 1'b0;
        case (state)
            SCAN: begin
                if (tick) begin
                    if (rows_s == 4'd0) begin
                        col_idx_n = col_idx + 2'd1;
                    end else begin
                        rows_lat_n = rows_s;
                        deb_cnt_n  = '0;
                        state_n    = DEBOUNCE;
                    end
                end
            end
            DEBOUNCE: begin
                if (tick) begin
                    if (rows_s == rows_lat) begin
                        deb_cnt_n = deb_cnt + 1'b1;
                        if (deb_cnt == DEB_LAST) begin
                            state_n     = PRESSED;
                            key_code_n  = {col_idx, low_row(rows_lat)};
                            key_valid_n = 1'b1;
                        end
                    end else begin
                        state_n   = SCAN;
                        col_idx_n = col_idx + 2'd1;
                    end
                end
            end
            PRESSED: begin
                if (tick && rows_s == 4'd0) begin
                    deb_cnt_n = '0;
                    state_n   = RELEASE;
                end
            end
            RELEASE: begin
                if (tick) begin
                    if (rows_s == 4'd0) begin
                        deb_cnt_n = deb_cnt + 1'b1;
                        if (deb_cnt == DEB_LAST) begin
                            state_n   = SCAN;
                            col_idx_n = col_idx + 2'd1;
                        end
                    end else begin
                        // A bounce back to active rows keeps the key held.
                        deb_cnt_n = '0;
                        state_n   = PRESSED;
                    end
                end
            end
            default: state_n = SCAN;
        endcase
    end

    assign columnas = col_onehot(col_idx);
    assign key_held = (state == PRESSED) || (state == RELEASE);

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: directed table, corner sequences and
// randomized rows checked every cycle against a behavioural model.
module tb_keypad_scan_ctrl;

    localparam int ST = 4;
    localparam int DT = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] filas_raw = 4'd0;
    logic [3:0] columnas;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    keypad_scan_ctrl #(
        .SCAN_TICKS(ST),
        .DEB_TICKS (DT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .filas_raw(filas_raw),
        .columnas (columnas),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    // Reference model: modes 0 idle-scan, 1 confirming, 2 held, 3 releasing.
    int         m_cnt = 0;
    int         m_mode = 0;
    int         m_col = 0;
    int         m_deb = 0;
    logic [3:0] m_s1 = 0;
    logic [3:0] m_s2 = 0;
    logic [3:0] m_lat = 0;
    logic [3:0] m_code = 0;
    logic       m_valid = 0;

    function automatic int lowest(input logic [3:0] r);
        for (int i = 0; i < 4; i++)
            if (r[i]) return i;
        return 3;
    endfunction

    always @(posedge clk) begin
        logic [3:0] rs;
        bit t;
        if (reset) begin
            m_cnt = 0; m_mode = 0; m_col = 0; m_deb = 0;
            m_s1 = 0; m_s2 = 0; m_lat = 0; m_code = 0; m_valid = 0;
        end else begin
            t = (m_cnt == ST - 1);
            m_cnt = t ? 0 : m_cnt + 1;
            rs = m_s2;
            m_s2 = m_s1;
            m_s1 = filas_raw;
            m_valid = 0;
            if (t) begin
                if (m_mode == 0) begin
                    if (rs == 0) m_col = (m_col + 1) % 4;
                    else begin m_lat = rs; m_deb = 0; m_mode = 1; end
                end else if (m_mode == 1) begin
                    if (rs == m_lat) begin
                        m_deb++;
                        if (m_deb == DT) begin
                            m_mode = 2; m_valid = 1;
                            m_code = 4'(m_col * 4 + lowest(m_lat));
                        end
                    end else begin
                        m_mode = 0; m_col = (m_col + 1) % 4;
                    end
                end else if (m_mode == 2) begin
                    if (rs == 0) begin m_deb = 0; m_mode = 3; end
                end else begin
                    if (rs == 0) begin
                        m_deb++;
                        if (m_deb == DT) begin
                            m_mode = 0; m_col = (m_col + 1) % 4;
                        end
                    end else begin
                        m_deb = 0; m_mode = 2;
                    end
                end
            end
        end
    end

    task automatic check(input string nm, input logic [3:0] act,
                         input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%b want=%b", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_columnas", columnas, 4'(4'b1000 >> m_col));
            check("m_key_code", key_code, m_code);
            check("m_key_valid", {3'b0, key_valid}, {3'b0, m_valid});
            check("m_key_held", {3'b0, key_held}, {3'b0, m_mode >= 2});
        end
    end

    int pulses;

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            if (key_valid) pulses++;
        end
    endtask

    task automatic wait_col(input logic [3:0] c);
        int k = 0;
        while (columnas == c && k < 64) begin cyc(1); k++; end
        while (columnas != c && k < 64) begin cyc(1); k++; end
        if (k >= 64) begin
            total++; bad++;
            $display("FAIL wait_col timeout got=%b want=%b", columnas, c);
        end
    endtask

    task automatic wait_mode(input int md);
        int k = 0;
        while (m_mode != md && k < 64) begin cyc(1); k++; end
        if (k >= 64) begin
            total++; bad++;
            $display("FAIL wait_mode timeout got=%0d want=%0d", m_mode, md);
        end
    endtask

    task automatic reset_check(input string nm);
        reset = 1'b1;
        pulses = 0;
        cyc(1);
        check({nm, "_col"}, columnas, 4'b1000);
        check({nm, "_code"}, key_code, 4'b0000);
        check({nm, "_held"}, {3'b0, key_held}, 4'd0);
        check({nm, "_valid"}, 4'(pulses), 4'd0);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [3:0] col;
        logic [3:0] rows;
        int         hold;
        int         pulses;
        logic [3:0] code;
        logic       held;
    } vec_t;

    vec_t vt[4];
    logic [3:0] rot[5];

    initial begin
        vt[0] = '{col: 4'b0100, rows: 4'b0010, hold: 30, pulses: 1,
                  code: 4'b0101, held: 1'b1};
        vt[1] = '{col: 4'b0010, rows: 4'b0001, hold: 4, pulses: 0,
                  code: 4'b0101, held: 1'b0};
        vt[2] = '{col: 4'b0001, rows: 4'b1010, hold: 30, pulses: 1,
                  code: 4'b1101, held: 1'b1};
        vt[3] = '{col: 4'b1000, rows: 4'b1000, hold: 30, pulses: 1,
                  code: 4'b0011, held: 1'b1};
        rot[0] = 4'b1000; rot[1] = 4'b0100; rot[2] = 4'b0010;
        rot[3] = 4'b0001; rot[4] = 4'b1000;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_col", columnas, 4'b1000);
        check("rst_code", key_code, 4'b0000);
        check("rst_valid", {3'b0, key_valid}, 4'd0);
        check("rst_held", {3'b0, key_held}, 4'd0);

        // Idle rotation after reset release.
        reset = 1'b0;
        pulses = 0;
        cyc(2);
        for (int i = 0; i < 5; i++) begin
            check("rotate", columnas, rot[i]);
            if (i < 4) cyc(4);
        end
        check("rotate_novalid", 4'(pulses), 4'd0);

        for (int i = 0; i < 4; i++) begin
            wait_col(vt[i].col);
            filas_raw = vt[i].rows;
            pulses = 0;
            cyc(vt[i].hold);
            check("vec_pulses", 4'(pulses), 4'(vt[i].pulses));
            check("vec_code", key_code, vt[i].code);
            check("vec_held", {3'b0, key_held}, {3'b0, vt[i].held});
            filas_raw = 4'd0;
            cyc(40);
            check("vec_rel_pulses", 4'(pulses), 4'(vt[i].pulses));
            check("vec_rel_held", {3'b0, key_held}, 4'd0);
        end

        // Release bounce is absorbed without a second press.
        wait_col(4'b0100);
        filas_raw = 4'b0010;
        cyc(30);
        filas_raw = 4'd0;
        pulses = 0;
        wait_mode(3);
        filas_raw = 4'b0001;
        cyc(4);
        check("bounce_held0", {3'b0, key_held}, 4'd1);
        filas_raw = 4'd0;
        cyc(10);
        check("bounce_held1", {3'b0, key_held}, 4'd1);
        cyc(20);
        check("bounce_held2", {3'b0, key_held}, 4'd0);
        check("bounce_pulses", 4'(pulses), 4'd0);
        check("bounce_code", key_code, 4'b0101);

        // Reset while confirming a press, then while held.
        filas_raw = 4'b0100;
        wait_mode(1);
        reset_check("rst_deb");
        cyc(30);
        check("pre_rst_held", {3'b0, key_held}, 4'd1);
        reset_check("rst_prs");
        filas_raw = 4'd0;
        cyc(40);

        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 2) == 0)
                filas_raw = 4'($urandom_range(1, 15));
            else
                filas_raw = 4'd0;
            if ($urandom_range(0, 59) == 0) begin
                reset = 1'b1;
                cyc(1);
                reset = 1'b0;
            end
            cyc($urandom_range(1, 24));
        end
        filas_raw = 4'd0;
        cyc(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
